// File: rtl/sysbus_mem_responder.sv
// Sysbus target: latches an address phase, counts WAIT_STATES, then reads or writes a 64-bit word memory.
// Optional SYSBUS_RESP_ERR_EN adds Err and suppresses accesses whose address has bits above ADDR_W set.
module sysbus_mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    inout  wire  [63:0] Sysbus,
    input  logic        ENB,
    input  logic        nALE,
    input  logic        nME,
    input  logic        RnW,
    input  logic        nOE,
    output logic        Ready,
`ifdef SYSBUS_RESP_ERR_EN
    output logic        Err,
`endif
    output logic        Busy
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rnw_q, rnw_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [63:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                mem_we;
    logic [63:0]         mem [2**ADDR_W];
`ifdef SYSBUS_RESP_ERR_EN
    logic                hi_q, hi_d;
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        mem_we  = 1'b0;
`ifdef SYSBUS_RESP_ERR_EN
        hi_d    = hi_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ENB && !nALE) begin
                    addr_d  = Sysbus[ADDR_W-1:0];
`ifdef SYSBUS_RESP_ERR_EN
                    hi_d    = |Sysbus[63:ADDR_W];
`endif
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!nME) begin
                    rnw_d   = RnW;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = WAIT;
                end else if (ENB && !nALE) begin
                    addr_d  = Sysbus[ADDR_W-1:0];
`ifdef SYSBUS_RESP_ERR_EN
                    hi_d    = |Sysbus[63:ADDR_W];
`endif
                end
            end
            WAIT: begin
                if (nME) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (rnw_q) rdata_d = mem[addr_q];
                    else       mem_we  = 1'b1;
`ifdef SYSBUS_RESP_ERR_EN
                    if (hi_q) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        mem_we  = 1'b0;
                    end
`endif
                end
            end
            DONE: begin
                if (nME) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
`ifdef SYSBUS_RESP_ERR_EN
            hi_q    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
`ifdef SYSBUS_RESP_ERR_EN
            hi_q    <= hi_d;
            err_q   <= err_d;
`endif
        end
    end

    // Memory is never cleared; reset only drops a write landing on the same edge.
    always_ff @(posedge Clock) begin
        if (mem_we && !Reset) mem[addr_q] <= Sysbus;
    end

    assign Sysbus = (state_q == DONE && rnw_q && !nOE) ? rdata_q : 'z;
    assign Ready  = ready_q;
    assign Busy   = (state_q != IDLE);
`ifdef SYSBUS_RESP_ERR_EN
    assign Err    = err_q;
`endif

endmodule
